// File: rtl/feed_sched_pkg.sv
// Shared types and defaults for the meal scheduler slice.
package feed_sched_pkg;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_ISSUE      = 2'd1,
    ST_WAIT_OPEN  = 2'd2,
    ST_WAIT_CLOSE = 2'd3
  } sched_state_t;

  // Default parameter values for a real-time deployment.
  localparam int unsigned DEF_TICKS_PER_MIN = 600000;
  localparam int unsigned DEF_MIN_PER_DAY   = 1440;
  localparam int unsigned DEF_NUM_MEALS     = 4;
  localparam int unsigned DEF_WEIGHT_W      = 7;
  localparam int unsigned DEF_HOLD_CYC      = 2;
  localparam int unsigned DEF_GATE_TMO      = 255;

  // Larger of two unsigned values, for sizing shared counters.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/feed_day_timer.sv
// Minute-of-day clock: prescaler, wrapping minute counter, time load,
// minute_tick and midnight newday indication.
module feed_day_timer
  import feed_sched_pkg::*;
#(
  parameter int unsigned TICKS_PER_MIN = DEF_TICKS_PER_MIN,
  parameter int unsigned MIN_PER_DAY   = DEF_MIN_PER_DAY,
  localparam int unsigned MIN_W   = $clog2(MIN_PER_DAY),
  localparam int unsigned PRESC_W = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             time_load,
  input  logic [MIN_W-1:0] time_value,
  output logic [MIN_W-1:0] minute_of_day,
  output logic [MIN_W-1:0] next_minute,
  output logic             minute_tick,
  output logic             newday
);

  logic [PRESC_W-1:0] presc_q;
  logic               at_last_min;

  // A load suppresses the tick, so a load never produces newday or a slot match.
  assign minute_tick = !time_load && (presc_q == PRESC_W'(TICKS_PER_MIN - 1));
  assign at_last_min = (minute_of_day == MIN_W'(MIN_PER_DAY - 1));
  assign next_minute = at_last_min ? '0 : minute_of_day + 1'b1;
  assign newday      = minute_tick && at_last_min;

  // Prescaler and minute counter; load has priority over the tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q       <= '0;
      minute_of_day <= '0;
    end else if (time_load) begin
      presc_q       <= '0;
      minute_of_day <= (32'(time_value) >= MIN_PER_DAY) ? '0 : time_value;
    end else if (minute_tick) begin
      presc_q       <= '0;
      minute_of_day <= next_minute;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

endmodule

// File: rtl/feed_schedule_ctrl.sv
// Meal scheduler: slot register file, pending vector, lowest-index pick,
// and the FSM that drives the food dispenser through one meal at a time.
module feed_schedule_ctrl
  import feed_sched_pkg::*;
#(
  parameter int unsigned TICKS_PER_MIN = DEF_TICKS_PER_MIN,
  parameter int unsigned MIN_PER_DAY   = DEF_MIN_PER_DAY,
  parameter int unsigned NUM_MEALS     = DEF_NUM_MEALS,
  parameter int unsigned WEIGHT_W      = DEF_WEIGHT_W,
  parameter int unsigned HOLD_CYC      = DEF_HOLD_CYC,
  parameter int unsigned GATE_TMO      = DEF_GATE_TMO,
  localparam int unsigned IDX_W = (NUM_MEALS > 1) ? $clog2(NUM_MEALS) : 1,
  localparam int unsigned MIN_W = $clog2(MIN_PER_DAY),
  localparam int unsigned CNT_W = $clog2(max_u(GATE_TMO, HOLD_CYC) + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_we,
  input  logic [IDX_W-1:0]    cfg_idx,
  input  logic                cfg_en,
  input  logic [MIN_W-1:0]    cfg_minute,
  input  logic [WEIGHT_W-1:0] cfg_weight,
  input  logic                time_load,
  input  logic [MIN_W-1:0]    time_value,
  input  logic                food_gate,
  output logic                timesup,
  output logic [WEIGHT_W-1:0] set_food_weight,
  output logic                newday,
  output logic [MIN_W-1:0]    minute_of_day,
  output logic                busy,
  output logic                meal_missed
);

  typedef struct packed {
    logic                en;
    logic [MIN_W-1:0]    minute;
    logic [WEIGHT_W-1:0] weight;
  } meal_slot_t;

  meal_slot_t          slots_q [NUM_MEALS];
  meal_slot_t          eff;
  logic [NUM_MEALS-1:0] pending_q, pending_d, pend_base, match, pick_mask;
  logic [WEIGHT_W-1:0]  pick_weight;
  logic [MIN_W-1:0]     next_minute;
  logic                 minute_tick, take, gate_tmo, overrun, missed_d;
  sched_state_t         state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  feed_day_timer #(
    .TICKS_PER_MIN(TICKS_PER_MIN),
    .MIN_PER_DAY  (MIN_PER_DAY)
  ) u_day_timer (
    .clk          (clk),
    .reset        (reset),
    .time_load    (time_load),
    .time_value   (time_value),
    .minute_of_day(minute_of_day),
    .next_minute  (next_minute),
    .minute_tick  (minute_tick),
    .newday       (newday)
  );

  assign timesup = (state_q == ST_ISSUE);
  assign busy    = (state_q != ST_IDLE);

  // Slot register file; out-of-range indices match no slot and are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_MEALS; i++) slots_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_MEALS; i++)
        if (cfg_we && cfg_idx == IDX_W'(i))
          slots_q[i] <= '{en: cfg_en, minute: cfg_minute, weight: cfg_weight};
    end
  end

  // Slot match (a same-cycle write is seen by the match) and lowest-index pick.
  always_comb begin
    eff         = '0;
    match       = '0;
    pick_mask   = '0;
    pick_weight = '0;
    for (int unsigned i = 0; i < NUM_MEALS; i++) begin
      eff = slots_q[i];
      if (cfg_we && cfg_idx == IDX_W'(i))
        eff = '{en: cfg_en, minute: cfg_minute, weight: cfg_weight};
      match[i] = minute_tick && eff.en && (eff.minute == next_minute);
      if (pending_q[i] && pick_mask == '0) begin
        pick_mask[i] = 1'b1;
        pick_weight  = slots_q[i].weight;
      end
    end
  end

  // Next-state logic with a shared per-state cycle counter reloaded on entry.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    take     = 1'b0;
    gate_tmo = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pending_q != '0) begin
          take    = 1'b1;
          state_d = ST_ISSUE;
          cnt_d   = '0;
        end
      end
      ST_ISSUE: begin
        if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
          state_d = ST_WAIT_OPEN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_OPEN: begin
        if (food_gate) begin
          state_d = ST_WAIT_CLOSE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(GATE_TMO - 1)) begin
          gate_tmo = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_CLOSE: begin
        if (!food_gate) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(GATE_TMO - 1)) begin
          gate_tmo = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pending/missed update: newday clears first, the issued slot is removed,
  // then matches land; a match on a still-pending slot is an overrun.
  always_comb begin
    pend_base = newday ? '0 : pending_q;
    if (take) pend_base = pend_base & ~pick_mask;
    overrun   = |(match & pend_base);
    pending_d = pend_base | match;
    missed_d  = (newday ? 1'b0 : meal_missed) | overrun | gate_tmo;
  end

  // State, counter, pending, missed flag and latched meal weight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      pending_q       <= '0;
      meal_missed     <= 1'b0;
      set_food_weight <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pending_q   <= pending_d;
      meal_missed <= missed_d;
      if (take) set_food_weight <= pick_weight;
    end
  end

endmodule

// File: tb/tb_feed_schedule_ctrl.sv
// Directed bench for feed_schedule_ctrl with a 4-cycle minute and 16-minute day.
module tb_feed_schedule_ctrl;

  localparam int unsigned TPM = 4;
  localparam int unsigned MPD = 16;
  localparam int unsigned NM  = 4;
  localparam int unsigned WW  = 7;
  localparam int unsigned HC  = 2;
  localparam int unsigned GT  = 8;

  logic          clk, reset, cfg_we, cfg_en, time_load, food_gate;
  logic [1:0]    cfg_idx;
  logic [3:0]    cfg_minute, time_value;
  logic [WW-1:0] cfg_weight;
  logic          timesup, newday, busy, meal_missed;
  logic [WW-1:0] set_food_weight;
  logic [3:0]    minute_of_day;

  int unsigned checks = 0;
  int unsigned passed = 0;
  int          gate_mode = 1;
  int          n;

  feed_schedule_ctrl #(
    .TICKS_PER_MIN(TPM),
    .MIN_PER_DAY  (MPD),
    .NUM_MEALS    (NM),
    .WEIGHT_W     (WW),
    .HOLD_CYC     (HC),
    .GATE_TMO     (GT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_we         (cfg_we),
    .cfg_idx        (cfg_idx),
    .cfg_en         (cfg_en),
    .cfg_minute     (cfg_minute),
    .cfg_weight     (cfg_weight),
    .time_load      (time_load),
    .time_value     (time_value),
    .food_gate      (food_gate),
    .timesup        (timesup),
    .set_food_weight(set_food_weight),
    .newday         (newday),
    .minute_of_day  (minute_of_day),
    .busy           (busy),
    .meal_missed    (meal_missed)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Dispenser stand-in: in mode 1 the gate opens 2 cycles after timesup rises
  // and closes 5 cycles later; other modes leave the gate to the main sequence.
  initial begin
    food_gate = 1'b0;
    forever begin
      @(posedge timesup);
      if (gate_mode == 1) begin
        repeat (2) @(posedge clk);
        #1 food_gate = 1'b1;
        repeat (5) @(posedge clk);
        #1 food_gate = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic write_slot(input int idx, input int en, input int minute, input int weight);
    cfg_we     = 1'b1;
    cfg_idx    = 2'(idx);
    cfg_en     = 1'(en);
    cfg_minute = 4'(minute);
    cfg_weight = WW'(weight);
    step();
    cfg_we = 1'b0;
  endtask

  task automatic load_time(input int v);
    time_load  = 1'b1;
    time_value = 4'(v);
    step();
    time_load = 1'b0;
  endtask

  task automatic wait_timesup(input string tag, input int max);
    int k = 0;
    while (timesup !== 1'b1 && k < max) begin step(); k++; end
    check(tag, 32'(timesup), 1);
  endtask

  task automatic wait_idle(input string tag, input int max);
    int k = 0;
    while (busy !== 1'b0 && k < max) begin step(); k++; end
    check(tag, 32'(busy), 0);
  endtask

  task automatic wait_newday(input string tag, input int max);
    int k = 0;
    while (newday !== 1'b1 && k < max) begin step(); k++; end
    check(tag, 32'(newday), 1);
  endtask

  initial begin
    reset = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0; cfg_minute = '0;
    cfg_weight = '0; time_load = 1'b0; time_value = '0;

    // Reset state
    repeat (3) step();
    check("rst_timesup", 32'(timesup), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_newday", 32'(newday), 0);
    check("rst_missed", 32'(meal_missed), 0);
    check("rst_minute", 32'(minute_of_day), 0);
    check("rst_weight", 32'(set_food_weight), 0);
    reset = 1'b1;
    step();

    // Single meal, slot0 at minute 3, weight 35
    gate_mode = 1;
    write_slot(0, 1, 3, 35);
    load_time(2);
    wait_timesup("m0_timesup", 20);
    check("m0_weight", 32'(set_food_weight), 35);
    check("m0_busy", 32'(busy), 1);
    n = 0;
    while (timesup === 1'b1 && n < 10) begin n++; step(); end
    check("m0_hold_len", 32'(n), 2);
    wait_idle("m0_idle", 20);
    check("m0_missed", 32'(meal_missed), 0);
    check("m0_weight_hold", 32'(set_food_weight), 35);
    write_slot(0, 0, 0, 0);

    // Two slots on minute 5: lowest index first
    write_slot(1, 1, 5, 12);
    write_slot(2, 1, 5, 20);
    load_time(4);
    wait_timesup("pri_first", 20);
    check("pri_weight1", 32'(set_food_weight), 12);
    wait_idle("pri_idle1", 20);
    wait_timesup("pri_second", 10);
    check("pri_weight2", 32'(set_food_weight), 20);
    wait_idle("pri_idle2", 20);
    check("pri_missed", 32'(meal_missed), 0);
    write_slot(1, 0, 0, 0);
    write_slot(2, 0, 0, 0);

    // Gate never opens: WAIT_OPEN timeout after 8 cycles
    gate_mode = 0;
    write_slot(0, 1, 9, 50);
    load_time(8);
    wait_timesup("tmo_timesup", 20);
    n = 0;
    while (timesup === 1'b1 && n < 10) begin n++; step(); end
    check("tmo_hold_len", 32'(n), 2);
    n = 0;
    while (busy === 1'b1 && n < 20) begin step(); n++; end
    check("tmo_wait_cycles", 32'(n), 8);
    check("tmo_missed", 32'(meal_missed), 1);
    write_slot(0, 0, 0, 0);
    wait_newday("tmo_newday", 80);
    check("tmo_missed_at_newday", 32'(meal_missed), 1);
    step();
    check("tmo_missed_cleared", 32'(meal_missed), 0);
    check("tmo_minute_wrap", 32'(minute_of_day), 0);

    // One full day from minute 0: exactly one newday
    load_time(0);
    n = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (newday === 1'b1) n++;
    end
    check("day_newday_count", 32'(n), 1);
    check("day_minute_end", 32'(minute_of_day), 0);

    // Load on the wrap tick cycle: no newday, minute 14, prescaler cleared
    load_time(15);
    repeat (3) step();
    check("wrap_newday_pending", 32'(newday), 1);
    time_load  = 1'b1;
    time_value = 4'd14;
    #1;
    check("load_masks_newday", 32'(newday), 0);
    step();
    time_load = 1'b0;
    check("load_minute", 32'(minute_of_day), 14);
    check("load_no_newday", 32'(newday), 0);
    repeat (3) step();
    check("load_presc_cleared", 32'(minute_of_day), 14);
    step();
    check("load_next_minute", 32'(minute_of_day), 15);

    // Overrun: slot3 matches again while still pending behind a long meal
    gate_mode = 2;
    food_gate = 1'b1;
    write_slot(2, 1, 6, 40);
    write_slot(3, 1, 7, 60);
    load_time(5);
    repeat (4) step();
    check("ovr_minute6", 32'(minute_of_day), 6);
    step();
    check("ovr_timesup", 32'(timesup), 1);
    check("ovr_weight40", 32'(set_food_weight), 40);
    repeat (3) step();
    cfg_we = 1'b1; cfg_idx = 2'd3; cfg_en = 1'b1; cfg_minute = 4'd8; cfg_weight = 7'd60;
    step();
    cfg_we = 1'b0;
    repeat (2) step();
    check("ovr_missed_before", 32'(meal_missed), 0);
    check("ovr_busy_before", 32'(busy), 1);
    step();
    check("ovr_missed", 32'(meal_missed), 1);
    check("ovr_busy", 32'(busy), 1);
    repeat (4) step();
    check("ovr_close_tmo_idle", 32'(busy), 0);
    step();
    check("ovr_reissue", 32'(timesup), 1);
    check("ovr_weight60", 32'(set_food_weight), 60);
    wait_idle("ovr_idle", 30);
    food_gate = 1'b0;
    write_slot(2, 0, 0, 0);
    write_slot(3, 0, 0, 0);

    // Reset asserted mid-ISSUE
    gate_mode = 0;
    write_slot(0, 1, 2, 10);
    load_time(1);
    wait_timesup("rmid_timesup", 20);
    reset = 1'b0;
    #1;
    check("rmid_timesup", 32'(timesup), 0);
    check("rmid_busy", 32'(busy), 0);
    check("rmid_newday", 32'(newday), 0);
    check("rmid_missed", 32'(meal_missed), 0);
    check("rmid_minute", 32'(minute_of_day), 0);
    check("rmid_weight", 32'(set_food_weight), 0);
    step();
    reset = 1'b1;
    step();
    check("rmid_minute_after", 32'(minute_of_day), 0);
    check("rmid_busy_after", 32'(busy), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
